// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Definitions shared by the VGA mode controller and its key debouncer:
//   - mode_t       : pattern select understood by the pattern generator
//   - deb_state_t  : pushbutton debounce FSM states
//   - default timing constants (50 MHz system clock)
//   - next_mode()  : modulo-4 mode advance
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_HBARS = 2'd0,
      MODE_VBARS = 2'd1,
      MODE_XOR   = 2'd2,
      MODE_XNOR  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      DEB_RELEASED     = 2'd0,
      DEB_PRESS_WAIT   = 2'd1,
      DEB_PRESSED      = 2'd2,
      DEB_RELEASE_WAIT = 2'd3
   } deb_state_t;

   // 10 ms of stable level at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES    = 500000;
   // two seconds per automatic step at 60 frames per second
   localparam int DEFAULT_AUTO_PERIOD_FRAMES = 120;

   // Four modes, so the 2-bit add wraps 3 -> 0 on its own.
   function automatic mode_t next_mode(input mode_t m);
      logic [1:0] nxt;
      nxt = m + 2'd1;
      return mode_t'(nxt);
   endfunction

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// vga_mode_ctrl_if
// Bundles the controller's user and video-timing signals.
//   key[1:0]      raw active-low pushbuttons (key[0]=next mode, key[1]=auto)
//   vsync         active-low vertical sync, one pulse per frame
//   mode          committed pattern select
//   auto_en       automatic mode cycling enabled
//   mode_changed  one-cycle pulse when mode takes a new value
// master: drives key/vsync and observes the outputs (board / bench side)
// slave : the controller itself
// -----------------------------------------------------------------------------
interface vga_mode_ctrl_if;
   import vga_pkg::*;

   logic [1:0] key;
   logic       vsync;
   mode_t      mode;
   logic       auto_en;
   logic       mode_changed;

   modport master (output key, vsync, input  mode, auto_en, mode_changed);
   modport slave  (input  key, vsync, output mode, auto_en, mode_changed);

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes one raw active-low pushbutton and debounces it, emitting a
// single-cycle press pulse once the key has been held stably low.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   key_n  raw pushbutton, active-low, asynchronous, bouncing
//   press  one-cycle pulse on an accepted press (nothing on release)
// -----------------------------------------------------------------------------
module key_debounce
   import vga_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic            key_s1;
   logic            key_s2;
   deb_state_t      state;
   logic [CW-1:0]   cnt;

   // Flops reset to the idle (released) level so reset release never looks
   // like a key going down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   // The counter only runs in the two WAIT states and is compared against
   // DEBOUNCE_CYCLES-1, so it never exceeds its range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DEB_RELEASED;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         case (state)
            DEB_RELEASED: begin
               cnt <= '0;
               if (!key_s2) state <= DEB_PRESS_WAIT;
            end
            DEB_PRESS_WAIT: begin
               if (key_s2) begin
                  state <= DEB_RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DEB_PRESSED;
                  cnt   <= '0;
                  press <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DEB_PRESSED: begin
               cnt <= '0;
               if (key_s2) state <= DEB_RELEASE_WAIT;
            end
            DEB_RELEASE_WAIT: begin
               if (!key_s2) begin
                  state <= DEB_PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DEB_RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= DEB_RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/vga_mode_ctrl.sv
// -----------------------------------------------------------------------------
// vga_mode_ctrl
// Selects the test pattern shown by the VGA pattern generator. key[0] steps
// the pattern, key[1] toggles automatic stepping every AUTO_PERIOD_FRAMES
// frames. Changes collect in a pending register and are committed to mode
// only right after a frame boundary, so the picture never changes mid-frame.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    vga_mode_ctrl_if.slave (key, vsync in; mode, auto_en,
//          mode_changed out)
// -----------------------------------------------------------------------------
module vga_mode_ctrl
   import vga_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
   parameter int AUTO_PERIOD_FRAMES = DEFAULT_AUTO_PERIOD_FRAMES
) (
   input  logic          clk,
   input  logic          rst_n,
   vga_mode_ctrl_if.slave bus
);

   localparam int FW = $clog2(AUTO_PERIOD_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_PERIOD_FRAMES - 1);

   logic [1:0]    press;
   logic          vsync_q;
   logic          frame_evt;
   logic          frame_evt_q;
   logic          auto_step;
   logic [FW-1:0] frame_cnt;
   mode_t         pending;
   mode_t         mode_r;
   logic          auto_en_r;
   logic          mode_changed_r;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key[0]),
      .press (press[0])
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_auto (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key[1]),
      .press (press[1])
   );

   assign frame_evt = vsync_q & ~bus.vsync;
   assign auto_step = auto_en_r & frame_evt & (frame_cnt == FRAME_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q        <= 1'b1;
         frame_evt_q    <= 1'b0;
         frame_cnt      <= '0;
         pending        <= MODE_HBARS;
         auto_en_r      <= 1'b0;
         mode_r         <= MODE_HBARS;
         mode_changed_r <= 1'b0;
      end else begin
         vsync_q     <= bus.vsync;
         frame_evt_q <= frame_evt;

         // A manual press and an auto step landing together still move one step.
         if (press[0] | auto_step) pending <= next_mode(pending);
         if (press[1])             auto_en_r <= ~auto_en_r;

         // Any press or auto step restarts the period, so a manual step
         // always gets a full period before the next automatic one.
         if (press[0] | press[1] | auto_step)
            frame_cnt <= '0;
         else if (auto_en_r & frame_evt)
            frame_cnt <= frame_cnt + 1'b1;

         // Commit one cycle after the frame boundary so the auto step taken
         // on that boundary is included.
         mode_changed_r <= 1'b0;
         if (frame_evt_q) begin
            mode_r         <= pending;
            mode_changed_r <= (pending != mode_r);
         end
      end
   end

   assign bus.mode         = mode_r;
   assign bus.auto_en      = auto_en_r;
   assign bus.mode_changed = mode_changed_r;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_mode_ctrl
// Directed scenarios plus a randomized run of the VGA mode controller with
// DEBOUNCE_CYCLES=4 and AUTO_PERIOD_FRAMES=3. A reference model tracks the
// debounced key level from run lengths of the synchronized key and applies
// the mode/auto rules; every predicted mode change is queued and matched
// against the DUT's mode_changed pulses by an independent monitor.
// -----------------------------------------------------------------------------
module tb_vga_mode_ctrl;
   import vga_pkg::*;

   localparam int DB = 4;
   localparam int AP = 3;

   logic clk = 1'b0;
   logic rst_n;

   vga_mode_ctrl_if mif ();

   vga_mode_ctrl #(
      .DEBOUNCE_CYCLES    (DB),
      .AUTO_PERIOD_FRAMES (AP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int pulse_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_mode, m_pend, m_fcnt;
   bit m_auto;
   bit ks1 [2];
   bit ks2 [2];
   int lowrun [2];
   int highrun [2];
   bit pressed [2];
   bit press_q [2];
   bit fe_q, vs_q;
   int exp_q [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_pend = 0; m_fcnt = 0; m_auto = 0;
         fe_q = 0; vs_q = 1;
         for (int k = 0; k < 2; k++) begin
            ks1[k] = 1; ks2[k] = 1; lowrun[k] = 0; highrun[k] = 0;
            pressed[k] = 0; press_q[k] = 0;
         end
         exp_q.delete();
      end else begin
         bit fe, step, auto_old, s;
         // commit of the pending value decided by the previous frame boundary
         if (fe_q) begin
            if (m_pend != m_mode) exp_q.push_back(m_pend);
            m_mode = m_pend;
         end
         fe       = vs_q && !mif.vsync;
         auto_old = m_auto;
         step     = auto_old && fe && (m_fcnt == AP - 1);
         if (press_q[0] || step) m_pend = (m_pend + 1) % 4;
         if (press_q[1]) m_auto = !m_auto;
         if (press_q[0] || press_q[1] || step) m_fcnt = 0;
         else if (auto_old && fe) m_fcnt = m_fcnt + 1;
         // debounced level: flips after DB+1 consecutive synchronized samples
         for (int k = 0; k < 2; k++) begin
            s = ks2[k];
            ks2[k] = ks1[k];
            ks1[k] = mif.key[k];
            if (!s) begin
               if (lowrun[k] < 1000) lowrun[k]++;
               highrun[k] = 0;
            end else begin
               if (highrun[k] < 1000) highrun[k]++;
               lowrun[k] = 0;
            end
            press_q[k] = 0;
            if (!pressed[k] && lowrun[k] == DB + 1) begin
               pressed[k] = 1;
               press_q[k] = 1;
            end else if (pressed[k] && highrun[k] == DB + 1) begin
               pressed[k] = 0;
            end
         end
         fe_q = fe;
         vs_q = mif.vsync;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && (mif.mode_changed || exp_q.size() > 0)) begin
         int e;
         chk("mode_changed", int'(mif.mode_changed), int'(exp_q.size() > 0));
         if (mif.mode_changed) pulse_cnt++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (mif.mode_changed) chk("committed_mode", int'(mif.mode), e);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic vs_pulse();
      mif.vsync = 1'b0;
      tick(1);
      mif.vsync = 1'b1;
      tick(3);
   endtask

   task automatic press_key(input int k, input int hold);
      mif.key[k] = 1'b0;
      tick(hold);
      mif.key[k] = 1'b1;
      tick(hold);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic checkpoint(input string name);
      chk({name, "_mode"}, int'(mif.mode), m_mode);
      chk({name, "_auto_en"}, int'(mif.auto_en), int'(m_auto));
      chk({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int hold [2];
      int vcnt;

      rst_n     = 1'b0;
      mif.key   = 2'b11;
      mif.vsync = 1'b1;
      tick(3);
      chk("reset_mode", int'(mif.mode), 0);
      chk("reset_auto_en", int'(mif.auto_en), 0);
      chk("reset_mode_changed", int'(mif.mode_changed), 0);
      rst_n = 1'b1;
      tick(2);

      // bounce shorter than the debounce time: no press
      mif.key[0] = 1'b0; tick(2);
      mif.key[0] = 1'b1; tick(1);
      mif.key[0] = 1'b0; tick(2);
      mif.key[0] = 1'b1; tick(10);
      vs_pulse();
      chk("bounce_mode", int'(mif.mode), 0);
      checkpoint("bounce");

      // one clean held press, committed at the next frame
      pulse_cnt = 0;
      press_key(0, 10);
      chk("press_before_frame_mode", int'(mif.mode), 0);
      vs_pulse();
      chk("press_mode", int'(mif.mode), 1);
      chk("press_pulses", pulse_cnt, 1);
      checkpoint("press");

      // four presses in one frame wrap pending back to its start
      do_reset();
      pulse_cnt = 0;
      for (int i = 0; i < 4; i++) press_key(0, 8);
      vs_pulse();
      chk("wrap_mode", int'(mif.mode), 0);
      chk("wrap_pulses", pulse_cnt, 0);
      checkpoint("wrap");

      // automatic stepping every AP frames
      do_reset();
      press_key(1, 8);
      chk("auto_on", int'(mif.auto_en), 1);
      pulse_cnt = 0;
      for (int i = 1; i <= 7; i++) begin
         vs_pulse();
         if (i == 2) chk("auto_f2_mode", int'(mif.mode), 0);
         if (i == 3) chk("auto_f3_mode", int'(mif.mode), 1);
         if (i == 5) chk("auto_f5_mode", int'(mif.mode), 1);
         if (i == 6) chk("auto_f6_mode", int'(mif.mode), 2);
      end
      chk("auto_pulses", pulse_cnt, 2);
      checkpoint("auto");

      // manual press landing on the same cycle as the auto step
      do_reset();
      press_key(1, 8);
      vs_pulse();
      vs_pulse();
      mif.key[0] = 1'b0;
      tick(DB + 3);
      mif.vsync = 1'b0;
      tick(1);
      mif.vsync = 1'b1;
      tick(3);
      mif.key[0] = 1'b1;
      tick(8);
      chk("coincide_mode", int'(mif.mode), 1);
      vs_pulse();
      vs_pulse();
      chk("coincide_f2_mode", int'(mif.mode), 1);
      vs_pulse();
      chk("coincide_f3_mode", int'(mif.mode), 2);
      checkpoint("coincide");

      // reset in the middle of a debounce with the key still held
      mif.key[0] = 1'b0;
      tick(5);
      rst_n = 1'b0;
      #1;
      chk("async_rst_mode", int'(mif.mode), 0);
      chk("async_rst_auto_en", int'(mif.auto_en), 0);
      chk("async_rst_mode_changed", int'(mif.mode_changed), 0);
      tick(2);
      rst_n = 1'b1;
      tick(DB);
      mif.key[0] = 1'b1;
      tick(10);
      vs_pulse();
      chk("rst_short_hold_mode", int'(mif.mode), 0);
      press_key(0, DB + 2);
      vs_pulse();
      chk("rst_full_hold_mode", int'(mif.mode), 1);
      checkpoint("rst_debounce");

      // randomized keys, vsync spacing and occasional resets
      do_reset();
      hold[0] = 10; hold[1] = 30; vcnt = 10;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (hold[k] == 0) begin
               mif.key[k] = ~mif.key[k];
               hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                     : $urandom_range(5, 14);
            end else begin
               hold[k]--;
            end
         end
         if (vcnt == 0) begin
            mif.vsync = 1'b0;
            vcnt = $urandom_range(4, 30);
         end else begin
            mif.vsync = 1'b1;
            vcnt--;
         end
         rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      rst_n     = 1'b1;
      mif.key   = 2'b11;
      mif.vsync = 1'b1;
      tick(20);
      vs_pulse();
      checkpoint("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
